// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg: shared encodings for the ALU issue stage
package alu_issuer_pkg;
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_OR = 4'd3,
    ALU_AND = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7,
    ALU_DIV = 4'd8,
    ALU_NA = 4'd15
  } alu_op_e;
  typedef enum logic [1:0] {
    CMP_EQU = 2'd0,
    CMP_LST = 2'd1,
    CMP_GRT = 2'd2,
    CMP_NA = 2'd3
  } cmp_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;
  function automatic logic branch_cond(input logic [2:0] f3, input logic [1:0] comp);
    return (comp == CMP_NA) ? 1'b0 :
           (f3 == F3_BEQ) ? (comp == CMP_EQU) :
           (f3 == F3_BNE) ? (comp != CMP_EQU) :
           (f3 == F3_BLT) ? (comp == CMP_LST) :
           (f3 == F3_BGE) ? (comp == CMP_EQU || comp == CMP_GRT) : 1'b0;
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps opcode/funct3/funct7 to an ALU op code and operand selects
module alu_op_decoder
  import alu_issuer_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output logic       use_imm,
  output logic       is_branch,
  output logic       illegal,
  output logic [2:0] br_f3
);
  // Decode one instruction; anything not matched stays NA and is flagged illegal
  always_comb begin
    alu_op = ALU_NA;
    use_imm = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OPC_R:
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_op = ALU_ADD;
          {F7_BASE, 3'b001}: alu_op = ALU_SLL;
          {F7_BASE, 3'b100}: alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: alu_op = ALU_SRL;
          {F7_BASE, 3'b110}: alu_op = ALU_OR;
          {F7_BASE, 3'b111}: alu_op = ALU_AND;
          {F7_ALT, 3'b000}: alu_op = ALU_SUB;
          {F7_MULDIV, 3'b000}: alu_op = ALU_MUL;
          {F7_MULDIV, 3'b100}: alu_op = ALU_DIV;
          default: alu_op = ALU_NA;
        endcase
      OPC_I: begin
        use_imm = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: alu_op = (funct7 == F7_BASE) ? ALU_SLL : ALU_NA;
          3'b101: alu_op = (funct7 == F7_BASE) ? ALU_SRL : ALU_NA;
          default: alu_op = ALU_NA;
        endcase
      end
      OPC_B:
        if (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE}) begin
          alu_op = ALU_SUB;
          is_branch = 1'b1;
        end
      default: alu_op = ALU_NA;
    endcase
  end
  assign illegal = (alu_op == ALU_NA);
  assign br_f3 = funct3;
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: multi-cycle issue stage presenting registered operands to the ALU and capturing its result
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [DATA_LENGTH-1:0] rs1_data,
  input  logic [DATA_LENGTH-1:0] rs2_data,
  input  logic [DATA_LENGTH-1:0] imm,
  output logic [DATA_LENGTH-1:0] alu_a,
  output logic [DATA_LENGTH-1:0] alu_b,
  output logic [3:0]             alu_op,
  input  logic [DATA_LENGTH-1:0] alu_result,
  input  logic [1:0]             alu_comp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] result,
  output logic                   branch_taken,
  output logic                   illegal
);
  alu_op_e dec_op;
  logic dec_use_imm, dec_is_branch, dec_illegal, dec_div0;
  logic [2:0] dec_br_f3;
  state_e state_q, state_d;
  logic [DATA_LENGTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
  alu_op_e alu_op_q, alu_op_d;
  logic taken_q, taken_d, illegal_q, illegal_d;
  logic pend_ill_q, pend_ill_d, div0_q, div0_d, is_br_q, is_br_d;
  logic [2:0] br_f3_q, br_f3_d;

  alu_op_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_op   (dec_op),
    .use_imm  (dec_use_imm),
    .is_branch(dec_is_branch),
    .illegal  (dec_illegal),
    .br_f3    (dec_br_f3)
  );

  assign dec_div0 = (dec_op == ALU_DIV) && (rs2_data == '0);

  // Next-state, operand latch on accept and result capture one cycle after issue
  always_comb begin
    state_d = state_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    taken_d = taken_q;
    illegal_d = illegal_q;
    pend_ill_d = pend_ill_q;
    div0_d = div0_q;
    is_br_d = is_br_q;
    br_f3_d = br_f3_q;
    case (state_q)
      S_IDLE:
        if (in_valid) begin
          state_d = S_EXEC;
          alu_a_d = rs1_data;
          alu_b_d = dec_use_imm ? imm : rs2_data;
          alu_op_d = dec_div0 ? ALU_NA : dec_op;
          pend_ill_d = dec_illegal;
          div0_d = dec_div0;
          is_br_d = dec_is_branch;
          br_f3_d = dec_br_f3;
        end
      S_EXEC: begin
        state_d = S_DONE;
        result_d = pend_ill_q ? '0 : div0_q ? '1 : alu_result;
        taken_d = is_br_q && branch_cond(br_f3_q, alu_comp);
        illegal_d = pend_ill_q;
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= ALU_NA;
      result_q <= '0;
      taken_q <= 1'b0;
      illegal_q <= 1'b0;
      pend_ill_q <= 1'b0;
      div0_q <= 1'b0;
      is_br_q <= 1'b0;
      br_f3_q <= '0;
    end else begin
      state_q <= state_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      taken_q <= taken_d;
      illegal_q <= illegal_d;
      pend_ill_q <= pend_ill_d;
      div0_q <= div0_d;
      is_br_q <= is_br_d;
      br_f3_q <= br_f3_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_op = alu_op_q;
  assign result = result_q;
  assign branch_taken = taken_q;
  assign illegal = illegal_q;
endmodule
